// File: rtl/cpu_pkg.sv
// Shared types and widths for the 19-bit pipelined CPU.
// Holds the MEM-stage FSM state type and the MEM/WB payload struct.
package cpu_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned REG_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rd;
    } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the writeback controls and
// holds the data fields.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              rdata_en,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_alu,
    output logic [REG_W-1:0]  wb_rd
);

    wb_t wb_q, wb_d;

    always_comb begin
        wb_d = wb_q;
        if (bubble) begin
            wb_d.regwrite = 1'b0;
            wb_d.memtoreg = 1'b0;
        end else begin
            wb_d.regwrite = regwrite_i;
            wb_d.memtoreg = memtoreg_i;
            wb_d.alu      = alu_i;
            wb_d.rd       = rd_i;
            if (rdata_en) begin
                wb_d.rdata = rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_regwrite = wb_q.regwrite;
    assign wb_memtoreg = wb_q.memtoreg;
    assign wb_rdata    = wb_q.rdata;
    assign wb_alu      = wb_q.alu;
    assign wb_rd       = wb_q.rd;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores on a ready/valid data-memory port and stalls upstream.
// Optional watchdog abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_regwrite,
    input  logic              MEM_memtoreg,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic [DATA_W-1:0] MEM_wdata,
    input  logic [REG_W-1:0]  MEM_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              WB_regwrite,
    output logic              WB_memtoreg,
    output logic [DATA_W-1:0] WB_rdata,
    output logic [DATA_W-1:0] WB_alu,
    output logic [REG_W-1:0]  WB_rd,
    output logic              mem_err
);

    mem_state_t state_q, state_d;

    logic access;
    logic is_store;
    logic store_done;
    logic load_done;
    logic done;
    logic abort;

    // Store wins when both read and write are requested.
    assign access     = MEM_memread | MEM_memwrite;
    assign is_store   = MEM_memwrite;
    assign store_done = is_store & dmem_ready &
                        (((state_q == IDLE) & access) | (state_q == REQ));
    assign load_done  = (state_q == WAIT_RD) & dmem_rvalid;
    assign done       = store_done | load_done;

    // Upstream is frozen while busy, so the MEM_* operands stay stable in REQ.
    assign dmem_we    = is_store;
    assign dmem_addr  = MEM_out;
    assign dmem_wdata = MEM_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    // Fires on the TIMEOUT-th busy cycle unless the transaction completes then.
    assign abort = (state_q != IDLE) & (cnt_q == CNT_W'(TIMEOUT - 1)) & ~done;

    always_comb begin
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        mem_err_d = mem_err_q | abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (dmem_ready) begin
                        state_d = is_store ? IDLE : WAIT_RD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_d = is_store ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Request and stall are held low for as long as reset is asserted.
    always_comb begin
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = access;
                mem_stall = access & ~done;
            end
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = ~done & ~abort;
            end
            WAIT_RD: begin
                mem_stall = ~done & ~abort;
            end
            default: ;
        endcase
        if (!rst_n) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble      (mem_stall),
        .regwrite_i  (MEM_regwrite & ~abort),
        .memtoreg_i  (MEM_memtoreg),
        .alu_i       (MEM_out),
        .rd_i        (MEM_rd),
        .rdata_en    (load_done | abort),
        .rdata_i     (abort ? '0 : dmem_rdata),
        .wb_regwrite (WB_regwrite),
        .wb_memtoreg (WB_memtoreg),
        .wb_rdata    (WB_rdata),
        .wb_alu      (WB_alu),
        .wb_rd       (WB_rd)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions against a transaction-level model of the memory handshake.
module tb_mem_access_stage;

    localparam int unsigned DW = 19;
    localparam int unsigned RW = 3;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
    logic [DW-1:0] MEM_out, MEM_wdata;
    logic [RW-1:0] MEM_rd;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ready, dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          mem_stall;
    logic          WB_regwrite, WB_memtoreg;
    logic [DW-1:0] WB_rdata, WB_alu;
    logic [RW-1:0] WB_rd;
    logic          mem_err;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_regwrite (MEM_regwrite),
        .MEM_memtoreg (MEM_memtoreg),
        .MEM_memread  (MEM_memread),
        .MEM_memwrite (MEM_memwrite),
        .MEM_out      (MEM_out),
        .MEM_wdata    (MEM_wdata),
        .MEM_rd       (MEM_rd),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .mem_stall    (mem_stall),
        .WB_regwrite  (WB_regwrite),
        .WB_memtoreg  (WB_memtoreg),
        .WB_rdata     (WB_rdata),
        .WB_alu       (WB_alu),
        .WB_rd        (WB_rd),
        .mem_err      (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction held in EX/MEM until the model says it completes.
    // d = cycles before ready, lat = cycles from acceptance to rvalid.
    task automatic run_instr(input logic rw, input logic mt, input logic rd_en, input logic wr_en,
                             input logic [DW-1:0] addr, input logic [DW-1:0] wdat,
                             input logic [RW-1:0] rd, input int d, input int lat,
                             input logic [DW-1:0] rdat);
        logic acc, st, ld, rv;
        int   total;
        acc   = rd_en | wr_en;
        st    = wr_en;
        ld    = acc & ~st;
        total = !acc ? 0 : (st ? d : d + lat);
        MEM_regwrite = rw;
        MEM_memtoreg = mt;
        MEM_memread  = rd_en;
        MEM_memwrite = wr_en;
        MEM_out      = addr;
        MEM_wdata    = wdat;
        MEM_rd       = rd;
        for (int k = 0; k <= total; k++) begin
            rv          = ld && (k == d + lat);
            dmem_ready  = acc ? (k == d) : 1'($urandom);
            dmem_rvalid = rv ? 1'b1 : ((!ld || k <= d) ? 1'($urandom) : 1'b0);
            dmem_rdata  = rv ? rdat : DW'($urandom);
            @(negedge clk);
            chk("dmem_req", 32'(dmem_req), 32'(acc && k <= d));
            if (acc && k <= d) begin
                chk("dmem_we", 32'(dmem_we), 32'(st));
                chk("dmem_addr", 32'(dmem_addr), 32'(addr));
                chk("dmem_wdata", 32'(dmem_wdata), 32'(wdat));
            end
            chk("mem_stall", 32'(mem_stall), 32'(k < total));
            @(posedge clk);
            #1;
            if (k < total) begin
                chk("bubble_regwrite", 32'(WB_regwrite), 32'd0);
                chk("bubble_memtoreg", 32'(WB_memtoreg), 32'd0);
            end else begin
                if (ld) exp_rdata = rdat;
                chk("wb_regwrite", 32'(WB_regwrite), 32'(rw));
                chk("wb_memtoreg", 32'(WB_memtoreg), 32'(mt));
                chk("wb_alu", 32'(WB_alu), 32'(addr));
                chk("wb_rd", 32'(WB_rd), 32'(rd));
                chk("wb_rdata", 32'(WB_rdata), 32'(exp_rdata));
                chk("mem_err", 32'(mem_err), 32'(exp_err));
            end
        end
    endtask

    initial begin
        int kind, d, lat;
        rst_n        = 1'b0;
        MEM_regwrite = 1'b0;
        MEM_memtoreg = 1'b0;
        MEM_memread  = 1'b0;
        MEM_memwrite = 1'b0;
        MEM_out      = '0;
        MEM_wdata    = '0;
        MEM_rd       = '0;
        dmem_ready   = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_regwrite", 32'(WB_regwrite), 32'd0);
        chk("rst_wb_alu", 32'(WB_alu), 32'd0);
        chk("rst_wb_rdata", 32'(WB_rdata), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: ALU op, zero-wait store, slow load, rvalid-in-idle with read/write conflict
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 19'h12345, 19'h0, 3'd5, 0, 0, 19'h0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 19'h00010, 19'h7FFFF, 3'd0, 0, 0, 19'h0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 19'h00200, 19'h0, 3'd3, 2, 3, 19'h0ABCD);
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 19'h00300, 19'h55555, 3'd1, 1, 0, 19'h0);

        // Randomized instruction mix and memory timing
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, 3));
            lat  = int'($urandom_range(1, 4));
            case (kind)
                0: run_instr(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom), RW'($urandom), 0, 0, '0);
                1: run_instr(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom), DW'($urandom), RW'($urandom), d, 0, '0);
                2: run_instr(1'b1, 1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom), RW'($urandom), d, lat, DW'($urandom));
                default: run_instr(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom), DW'($urandom), RW'($urandom), d, 0, '0);
            endcase
        end

        // Reset while waiting for load data, then the held load is re-issued
        MEM_regwrite = 1'b1;
        MEM_memtoreg = 1'b1;
        MEM_memread  = 1'b1;
        MEM_memwrite = 1'b0;
        MEM_out      = 19'h04444;
        MEM_wdata    = '0;
        MEM_rd       = 3'd6;
        dmem_ready   = 1'b1;
        dmem_rvalid  = 1'b0;
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("waitrd_stall", 32'(mem_stall), 32'd1);
        chk("waitrd_req", 32'(dmem_req), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_regwrite", 32'(WB_regwrite), 32'd0);
        chk("midrst_wb_rdata", 32'(WB_rdata), 32'd0);
        chk("midrst_wb_alu", 32'(WB_alu), 32'd0);
        chk("midrst_wb_rd", 32'(WB_rd), 32'd0);
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_mem_stall", 32'(mem_stall), 32'd0);
        exp_rdata = '0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 19'h3FFFF;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        rst_n = 1'b1;
        chk("late_rvalid_rdata", 32'(WB_rdata), 32'd0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 19'h04444, 19'h0, 3'd6, 1, 2, 19'h01234);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: ready never arrives, load is aborted and the error sticks
        MEM_regwrite = 1'b1;
        MEM_memtoreg = 1'b1;
        MEM_memread  = 1'b1;
        MEM_memwrite = 1'b0;
        MEM_out      = 19'h00777;
        MEM_rd       = 3'd2;
        dmem_ready   = 1'b0;
        dmem_rvalid  = 1'b0;
        for (int k = 0; k <= int'(TO); k++) begin
            @(negedge clk);
            chk("to_stall", 32'(mem_stall), 32'(k < int'(TO)));
            @(posedge clk);
            #1;
        end
        exp_rdata = '0;
        exp_err   = 1'b1;
        chk("to_wb_regwrite", 32'(WB_regwrite), 32'd0);
        chk("to_wb_rdata", 32'(WB_rdata), 32'd0);
        chk("to_mem_err", 32'(mem_err), 32'd1);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 19'h00042, 19'h0, 3'd4, 0, 0, 19'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
